// File: rtl/debounce_pkg.sv
// Shared debounce constants and the button channel map used by the vending FSM.
// Build option DEBOUNCE_RISE_PULSE_EN (see debounce_channel) enables rising-edge pulses.
package debounce_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  // Bit positions of the buttons on the debouncer i_raw/o_level buses.
  localparam int BTN_CONFIRM = 0;
  localparam int BTN_100     = 1;
  localparam int BTN_50      = 2;

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchroniser, stability counter, level flop, optional pulse.
// Macro DEBOUNCE_RISE_PULSE_EN adds a registered pulse on accepted 0->1; otherwise o_rise is 0.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  logic             sync_s1_q;
  logic             sync_s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;

  // The counter clears whenever s2 agrees with the level or a change is accepted,
  // so it never exceeds DEBOUNCE_CYCLES-1 and cannot wrap.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync_s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_s1_q <= 1'b0;
      sync_s2_q <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
    end else begin
      sync_s1_q <= i_raw;
      sync_s2_q <= sync_s1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
    end
  end

  assign o_level = level_q;

`ifdef DEBOUNCE_RISE_PULSE_EN
  logic rise_q;
  logic rise_d;

  always_comb begin
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
    end
  end

  assign o_rise = rise_q;
`else
  assign o_rise = 1'b0;
`endif

endmodule

// File: rtl/input_debouncer.sv
// Push-button front end: WIDTH independent debounce lanes feeding the vending FSM x input.
// Rising-edge pulses on o_rise exist only when DEBOUNCE_RISE_PULSE_EN is defined.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_rise
);

  for (genvar k = 0; k < WIDTH; k++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (i_raw[k]),
      .o_level (o_level[k]),
      .o_rise  (o_rise[k])
    );
  end

endmodule
